// File: rtl/beta_pkg.sv
// Shared definitions for the Beta processor blocks.
//   fetch_state_t : state encoding of the instruction fetch unit
//   FAULT_INSTR   : word handed to decode when a fetch faults
//   RESET_VECTOR  : first instruction address after reset (also used by pc)
package beta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] FAULT_INSTR  = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;

endpackage

// File: rtl/fetch_timer.sv
// Clearable up-counter that measures how long a memory request has been
// outstanding.
//   clk, reset : clock and asynchronous active-high reset
//   i_clear    : force the count back to zero (has priority over i_inc)
//   i_inc      : advance the count by one
//   o_expired  : count has reached TIMEOUT-1
module fetch_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    // A TIMEOUT of 1 would give a zero-width counter, so keep at least one bit.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;

    assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

    // The count saturates at the expiry value so it never wraps back to a
    // value that would hide the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit for the Beta.
// Turns the instruction address from pc into a read on the instruction
// memory port and hands the fetched word to decode with a valid/ready
// handshake. pc is held via pc_stall until decode has taken the word.
// A misaligned address or a memory that never answers yields a fault word
// instead of a hang.
//   clk, reset   : clock and asynchronous active-high reset
//   ia           : instruction address from pc (stable while pc_stall=1)
//   pc_stall     : pc must hold ia
//   mem_req      : read request to instruction memory
//   mem_addr     : word address of the request
//   mem_ack      : read complete, mem_rdata valid
//   mem_rdata    : read data
//   instr        : fetched instruction (FAULT_INSTR on a fault)
//   instr_ia     : address instr came from
//   instr_valid  : instr, instr_ia and fetch_fault are valid
//   instr_ready  : decode accepts the instruction
//   fetch_fault  : timeout or misaligned address
module ifetch
    import beta_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ia,
    output logic              pc_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr,
    output logic [31:0]       instr_ia,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_fault
);

    fetch_state_t r_state;
    fetch_state_t w_nextState;

    logic [31:0] r_instr;
    logic [31:0] r_instrIa;
    logic        r_fault;

    logic w_aligned;
    logic w_expired;
    logic w_loadData;
    logic w_loadFault;
    logic w_timerClear;
    logic w_timerInc;

    assign w_aligned = (ia[1:0] == 2'b00);

    // The timer sits at zero outside REQ, so each REQ entry starts from a
    // cleared count. It only advances on cycles the memory did not answer.
    assign w_timerClear = (r_state != REQ);
    assign w_timerInc   = (r_state == REQ) && !mem_ack;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_timerClear),
        .i_inc     (w_timerInc),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. The request address is taken
    // straight from ia while in REQ: pc advances on the same edge that
    // enters REQ, so the new address only exists after that edge, and pc
    // holds it for the whole REQ visit. pc_stall depends only on the state
    // and instr_ready, never on the memory side.
    always_comb begin
        w_nextState = r_state;
        w_loadData  = 1'b0;
        w_loadFault = 1'b0;
        pc_stall    = 1'b1;
        mem_req     = 1'b0;
        mem_addr    = '0;
        instr_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextState = REQ;
            end
            REQ: begin
                if (!w_aligned) begin
                    w_loadFault = 1'b1;
                    w_nextState = HOLD;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = ia[ADDR_W+1:2];
                    // An ack on the expiry cycle still counts as a good fetch.
                    if (mem_ack) begin
                        w_loadData  = 1'b1;
                        w_nextState = HOLD;
                    end else if (w_expired) begin
                        w_loadFault = 1'b1;
                        w_nextState = HOLD;
                    end
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                pc_stall    = ~instr_ready;
                if (instr_ready) begin
                    w_nextState = REQ;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Result registers change only on the edge that enters HOLD, which
    // keeps them stable while decode is back-pressuring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr   <= '0;
            r_instrIa <= '0;
            r_fault   <= 1'b0;
        end else if (w_loadData) begin
            r_instr   <= mem_rdata;
            r_instrIa <= ia;
            r_fault   <= 1'b0;
        end else if (w_loadFault) begin
            r_instr   <= FAULT_INSTR;
            r_instrIa <= ia;
            r_fault   <= 1'b1;
        end
    end

    assign instr       = r_instr;
    assign instr_ia    = r_instrIa;
    assign fetch_fault = r_fault;

endmodule
